irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 117 +++++++++++
 tb/tb_irq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - edge-triggered interrupt controller with claim/complete and a software interrupt bit
module irq_ctrl #(
  parameter int NUM_SRC = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_SRC-1:0] i_src,
  input  logic               i_req,
  input  logic               i_we,
  input  logic [3:0]         i_addr,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic               o_ack,
  output logic               o_external_interrupt,
  output logic               o_software_interrupt
);
  localparam logic [1:0] A_PENDING = 2'd0;
  localparam logic [1:0] A_ENABLE  = 2'd1;
  localparam logic [1:0] A_CLAIM   = 2'd2;
  localparam logic [1:0] A_MSIP    = 2'd3;

  logic [NUM_SRC-1:0] r_src_q;
  logic               r_armed;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_in_service;
  logic               r_msip;
  logic               r_ack;
  logic [31:0]        r_rdata;
  logic               r_ext_irq;

  logic               w_access;
  logic               w_rd;
  logic               w_wr;
  logic [1:0]         w_word;
  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_cand;
  logic [NUM_SRC-1:0] w_claim_oh;
  logic [NUM_SRC-1:0] w_cmp_oh;
  logic [NUM_SRC-1:0] w_claim_set;
  logic [NUM_SRC-1:0] w_cmp_clr;
  logic [4:0]         w_claim_id;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_unused = ^i_addr[1:0];
  assign w_word   = i_addr[3:2];
  assign w_access = i_req & ~r_ack;
  assign w_rd     = w_access & ~i_we;
  assign w_wr     = w_access & i_we;

  // r_armed masks the first post-reset edge so a level held high through reset is not an edge
  assign w_edge = i_src & ~r_src_q & {NUM_SRC{r_armed}};
  assign w_cand = r_pending & r_enable & ~r_in_service;

  always_comb begin
    w_claim_id = '0;
    w_claim_oh = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_cand[k]) begin
        w_claim_id    = 5'(k + 1);
        w_claim_oh    = '0;
        w_claim_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_cmp_oh = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (i_wdata == 32'(k + 1)) w_cmp_oh[k] = 1'b1;
    end
  end

  assign w_claim_set = (w_rd && w_word == A_CLAIM) ? w_claim_oh : '0;
  assign w_cmp_clr   = (w_wr && w_word == A_CLAIM) ? (w_cmp_oh & r_in_service) : '0;

  always_comb begin
    w_rdata = '0;
    case (w_word)
      A_PENDING: w_rdata[NUM_SRC-1:0] = r_pending;
      A_ENABLE:  w_rdata[NUM_SRC-1:0] = r_enable;
      A_CLAIM:   w_rdata[4:0]         = w_claim_id;
      default:   w_rdata[0]           = r_msip;
    endcase
  end

  // a new edge wins over a claim clearing the same pending bit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_src_q      <= '0;
      r_armed      <= 1'b0;
      r_pending    <= '0;
      r_enable     <= '0;
      r_in_service <= '0;
      r_msip       <= 1'b0;
      r_ack        <= 1'b0;
      r_rdata      <= '0;
      r_ext_irq    <= 1'b0;
    end else begin
      r_src_q      <= i_src;
      r_armed      <= 1'b1;
      r_pending    <= (r_pending & ~w_claim_set) | w_edge;
      r_in_service <= (r_in_service | w_claim_set) & ~w_cmp_clr;
      if (w_wr && w_word == A_ENABLE) r_enable <= i_wdata[NUM_SRC-1:0];
      if (w_wr && w_word == A_MSIP)   r_msip   <= i_wdata[0];
      r_ack        <= w_access;
      r_rdata      <= w_rd ? w_rdata : '0;
      r_ext_irq    <= |w_cand;
    end
  end

  assign o_rdata              = r_rdata;
  assign o_ack                = r_ack;
  assign o_external_interrupt = r_ext_irq;
  assign o_software_interrupt = r_msip;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed and randomized checks of irq_ctrl against a behavioural model
module tb_irq_ctrl;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  src = '0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [3:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          ack;
  logic          ext;
  logic          sw;

  always #5 clk = ~clk;

  irq_ctrl #(.NUM_SRC(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_src(src), .i_req(req), .i_we(we),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_ack(ack),
    .o_external_interrupt(ext), .o_software_interrupt(sw)
  );

  int n_cmp = 0;
  int n_fail = 0;

  bit          m_pend[N];
  bit          m_en[N];
  bit          m_ins[N];
  bit          m_prev[N];
  bit          m_seen, m_msip, m_ack, m_ext, m_rd_valid;
  logic [31:0] m_rdata;

  function automatic int lowest_claimable();
    for (int k = 0; k < N; k++)
      if (m_pend[k] && m_en[k] && !m_ins[k]) return k + 1;
    return 0;
  endfunction

  // one clock edge of the reference model, applied to the inputs the bench is driving
  task automatic model_edge();
    bit edges[N];
    bit claimed[N];
    bit acc;
    int id;
    int w;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_pend[k] = 0; m_en[k] = 0; m_ins[k] = 0; m_prev[k] = 0;
      end
      m_seen = 0; m_msip = 0; m_ack = 0; m_ext = 0;
      m_rdata = 0; m_rd_valid = 1;
      return;
    end
    acc = req && !m_ack;
    m_ext = (lowest_claimable() != 0);
    m_rdata = 0;
    m_rd_valid = acc;
    w = int'(addr[3:2]);
    for (int k = 0; k < N; k++) begin
      edges[k] = m_seen && src[k] && !m_prev[k];
      claimed[k] = 0;
    end
    if (acc && !we) begin
      if (w == 0) begin
        for (int k = 0; k < N; k++) if (m_pend[k]) m_rdata[k] = 1'b1;
      end else if (w == 1) begin
        for (int k = 0; k < N; k++) if (m_en[k]) m_rdata[k] = 1'b1;
      end else if (w == 2) begin
        id = lowest_claimable();
        m_rdata = 32'(id);
        if (id != 0) begin
          claimed[id-1] = 1;
          m_ins[id-1] = 1;
        end
      end else begin
        m_rdata[0] = m_msip;
      end
    end
    if (acc && we) begin
      if (w == 1) begin
        for (int k = 0; k < N; k++) m_en[k] = wdata[k];
      end else if (w == 2) begin
        if (wdata >= 1 && wdata <= N && m_ins[wdata-1]) m_ins[wdata-1] = 0;
      end else if (w == 3) begin
        m_msip = wdata[0];
      end
    end
    for (int k = 0; k < N; k++) begin
      m_pend[k] = edges[k] || (m_pend[k] && !claimed[k]);
      m_prev[k] = src[k];
    end
    m_seen = 1;
    m_ack = acc;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ack", 32'(ack), 32'(m_ack));
    chk("ext_irq", 32'(ext), 32'(m_ext));
    chk("sw_irq", 32'(sw), 32'(m_msip));
    if (m_rd_valid) chk("rdata", rdata, m_rdata);
  endtask

  task automatic access(input bit w, input logic [3:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    rd = rdata;
    req = 1'b0; we = 1'b0;
    tick();
  endtask

  logic [31:0] rd, p0, e0;

  initial begin
    // reset state
    rst = 1'b1;
    tick(); tick();
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    tick();

    // single source: enable, edge, claim, complete
    access(1, 4'h4, 32'h1, rd);
    src[0] = 1'b1; tick();
    tick();
    chk("s0_ext_raised", 32'(ext), 32'd1);
    access(0, 4'h0, 0, rd); chk("s0_pending", rd, 32'h1);
    access(0, 4'h8, 0, rd); chk("s0_claim", rd, 32'd1);
    chk("s0_ext_after_claim", 32'(ext), 32'd0);
    access(1, 4'h8, 32'd1, rd);
    src[0] = 1'b0; tick();

    // simultaneous edges claimed in ascending order
    access(1, 4'h4, 32'hF, rd);
    src = 4'b0110; tick(); tick();
    access(0, 4'h8, 0, rd); chk("multi_claim_a", rd, 32'd2);
    access(0, 4'h8, 0, rd); chk("multi_claim_b", rd, 32'd3);
    access(0, 4'h8, 0, rd); chk("multi_claim_c", rd, 32'd0);
    access(1, 4'h8, 32'd2, rd);
    access(1, 4'h8, 32'd3, rd);
    src = '0; tick();

    // re-edge while in service stays masked until complete
    src[0] = 1'b1; tick(); tick();
    access(0, 4'h8, 0, rd); chk("reedge_claim", rd, 32'd1);
    src[0] = 1'b0; tick();
    src[0] = 1'b1; tick(); tick(); tick();
    chk("reedge_masked", 32'(ext), 32'd0);
    access(0, 4'h0, 0, rd); chk("reedge_pending", rd, 32'h1);
    access(1, 4'h8, 32'd1, rd);
    chk("reedge_after_complete", 32'(ext), 32'd1);
    access(0, 4'h8, 0, rd); chk("reedge_claim2", rd, 32'd1);
    access(1, 4'h8, 32'd1, rd);
    src = '0; tick();

    // bad completes leave state untouched
    access(1, 4'h4, 32'h7, rd);
    src[3] = 1'b1; tick(); tick();
    access(0, 4'h0, 0, p0);
    access(0, 4'h4, 0, e0);
    access(1, 4'h8, 32'd3, rd);
    access(1, 4'h8, 32'd9, rd);
    access(1, 4'h8, 32'd0, rd);
    access(1, 4'h0, 32'hF, rd);
    access(0, 4'h0, 0, rd); chk("badcmp_pending", rd, 32'h8);
    chk("badcmp_pending_same", rd, p0);
    access(0, 4'h4, 0, rd); chk("badcmp_enable", rd, 32'h7);
    chk("badcmp_enable_same", rd, e0);
    access(0, 4'h8, 0, rd); chk("badcmp_claim", rd, 32'd0);
    access(1, 4'h4, 32'hF, rd);
    chk("reenable_ext", 32'(ext), 32'd1);
    access(0, 4'h8, 0, rd); chk("reenable_claim", rd, 32'd4);
    access(1, 4'h8, 32'd4, rd);
    src = '0; tick();

    // software interrupt
    access(1, 4'hC, 32'h1, rd);
    chk("msip_set", 32'(sw), 32'd1);
    access(0, 4'hC, 0, rd); chk("msip_read1", rd, 32'h1);
    access(1, 4'hC, 32'h0, rd);
    chk("msip_clr", 32'(sw), 32'd0);
    access(0, 4'hD, 0, rd); chk("msip_read0", rd, 32'h0);

    // level high through reset release, then reset during an access
    src[0] = 1'b1; rst = 1'b1; tick(); tick();
    rst = 1'b0; tick(); tick();
    access(0, 4'h0, 0, rd); chk("level_through_reset", rd, 32'h0);
    req = 1'b1; we = 1'b1; addr = 4'h4; wdata = 32'hF; rst = 1'b1;
    tick();
    chk("abort_no_ack_a", 32'(ack), 32'd0);
    req = 1'b0; we = 1'b0; rst = 1'b0;
    tick();
    chk("abort_no_ack_b", 32'(ack), 32'd0);
    access(0, 4'h4, 0, rd); chk("abort_enable", rd, 32'h0);
    src = '0; tick();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) src = src ^ N'($urandom);
      rst = ($urandom_range(0, 79) == 0);
      req = $urandom_range(0, 1) == 1;
      we = $urandom_range(0, 1) == 1;
      addr = {2'($urandom_range(0, 3)), 2'($urandom)};
      wdata = (addr[3:2] == 2'd2) ? 32'($urandom_range(0, N + 2)) : $urandom;
      tick();
    end
    rst = 1'b0; req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
